// File: rtl/gcd_job_sequencer_if.sv
// gcd_job_sequencer_if: bundles the job handshake, result handshake and core
// operand/control signals of the GCD job sequencer.
// The slave modport is the sequencer's own view. The master modport is the view
// of everything around it: the job source, the result sink and the GCD core.
// Build option: GCD_CYCLE_COUNT_EN adds the out_cycles result field.
interface gcd_job_sequencer_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_x;
    logic [W-1:0] in_y;
    logic [W-1:0] core_x;
    logic [W-1:0] core_y;
    logic         core_load;
    logic         core_abort;
    logic         core_done;
    logic [W-1:0] core_gcd;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_gcd;
    logic         out_err;
`ifdef GCD_CYCLE_COUNT_EN
    logic [15:0]  out_cycles;
`endif

    modport slave (
        input  in_valid,
        input  in_x,
        input  in_y,
        input  core_done,
        input  core_gcd,
        input  out_ready,
        output in_ready,
        output core_x,
        output core_y,
        output core_load,
        output core_abort,
        output out_valid,
        output out_gcd,
        output out_err
`ifdef GCD_CYCLE_COUNT_EN
        , output out_cycles
`endif
    );

    modport master (
        output in_valid,
        output in_x,
        output in_y,
        output core_done,
        output core_gcd,
        output out_ready,
        input  in_ready,
        input  core_x,
        input  core_y,
        input  core_load,
        input  core_abort,
        input  out_valid,
        input  out_gcd,
        input  out_err
`ifdef GCD_CYCLE_COUNT_EN
        , input out_cycles
`endif
    );
endinterface

// File: rtl/gcd_job_sequencer.sv
// gcd_job_sequencer: front-end for the GCD controller/datapath pair.
// Accepts an operand pair, holds it on the core operand bus, pulses the core
// load, waits for a fresh done level and returns the result over a valid/ready
// handshake. Zero operands bypass the core (gcd(0,n)=n). A job that runs
// TIMEOUT cycles past its load pulse is aborted and reported with out_err=1.
// Build option: GCD_CYCLE_COUNT_EN adds out_cycles, the number of cycles from
// the load cycle (exclusive) to the capture cycle (inclusive).
module gcd_job_sequencer #(
    parameter int W       = 8,
    parameter int TIMEOUT = 1024
) (
    input logic                clk,
    input logic                rst,
    gcd_job_sequencer_if.slave bus
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_CLR,
        WAIT_DONE,
        RESP
    } state_t;

    state_t        state_q;
    state_t        state_d;

    logic [CW-1:0] cnt_q;
    logic [W-1:0]  x_q;
    logic [W-1:0]  y_q;
    logic [W-1:0]  gcd_q;
    logic          err_q;

    logic          zero_op;
    logic          expire;
    logic          waiting;
    logic          accept;

    logic          in_ready_c;
    logic          out_valid_c;
    logic          load_c;
    logic          abort_c;
    logic          capture_c;

    // A pair containing a zero never reaches the core: its subtract loop would not terminate.
    assign zero_op = (bus.in_x == '0) || (bus.in_y == '0);

    // The counter is cleared in LAUNCH, so it holds k-2 in the k-th cycle after
    // the accept; expire marks the cycle in which it steps up to TIMEOUT.
    assign expire  = (cnt_q == CNT_LAST);
    assign waiting = (state_q == WAIT_CLR) || (state_q == WAIT_DONE);
    assign accept  = in_ready_c && bus.in_valid;

    // State register; rst drops any in-flight job without a result or abort pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode; handshake and core strobes all come from here.
    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        load_c      = 1'b0;
        abort_c     = 1'b0;
        capture_c   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    state_d = zero_op ? RESP : LAUNCH;
                end
            end
            LAUNCH: begin
                load_c  = 1'b1;
                state_d = WAIT_CLR;
            end
            WAIT_CLR: begin
                if (expire) begin
                    abort_c = 1'b1;
                    state_d = RESP;
                end else if (!bus.core_done) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus.core_done) begin
                    capture_c = 1'b1;
                    state_d   = RESP;
                end else if (expire) begin
                    abort_c = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand, result and timeout registers; operands change only on an accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q   <= '0;
            y_q   <= '0;
            gcd_q <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (accept) begin
                x_q <= bus.in_x;
                y_q <= bus.in_y;
                if (zero_op) begin
                    gcd_q <= bus.in_x | bus.in_y;
                    err_q <= 1'b0;
                end
            end
            if (load_c) begin
                cnt_q <= '0;
            end else if (waiting) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (capture_c) begin
                gcd_q <= bus.core_gcd;
                err_q <= 1'b0;
            end else if (abort_c) begin
                gcd_q <= '0;
                err_q <= 1'b1;
            end
        end
    end

`ifdef GCD_CYCLE_COUNT_EN
    logic [15:0] cyc_q;
    logic [15:0] cycles_q;
    logic [15:0] cyc_inc;

    assign cyc_inc = (cyc_q == 16'hFFFF) ? 16'hFFFF : cyc_q + 16'd1;

    // Saturating job-duration counter; the capture or abort cycle is included in the report.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q    <= '0;
            cycles_q <= '0;
        end else begin
            if (load_c) begin
                cyc_q <= '0;
            end else if (waiting) begin
                cyc_q <= cyc_inc;
            end
            if (accept && zero_op) begin
                cycles_q <= '0;
            end else if (capture_c || abort_c) begin
                cycles_q <= cyc_inc;
            end
        end
    end

    assign bus.out_cycles = cycles_q;
`endif

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_c;
    assign bus.core_load  = load_c;
    assign bus.core_abort = abort_c;
    assign bus.core_x     = x_q;
    assign bus.core_y     = y_q;
    assign bus.out_gcd    = gcd_q;
    assign bus.out_err    = err_q;

    // Load and abort come from disjoint states, so they can never coincide.
    a_load_abort_exclusive: assert property (
        @(posedge clk) disable iff (rst) !(load_c && abort_c)
    );

    // A pending result must not change while the consumer stalls.
    a_result_held: assert property (
        @(posedge clk) disable iff (rst)
        (out_valid_c && !bus.out_ready) |=> ($stable(gcd_q) && $stable(err_q))
    );

    // The core operand bus only moves on an accepted pair.
    a_operands_held: assert property (
        @(posedge clk) disable iff (rst)
        !accept |=> ($stable(x_q) && $stable(y_q))
    );

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// tb_gcd_job_sequencer: scoreboard bench for gcd_job_sequencer.
// A behavioural subtract-GCD core answers the load pulses. It can be told to
// hold a stale done for a few cycles after a load, or to hang so that the
// timeout fires. Expected results are queued when a pair is issued; a negedge
// monitor pops and compares each transferred result.
module tb_gcd_job_sequencer;

    localparam int W       = 8;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] gcd;
        logic         err;
        int           loads;
        int           aborts;
        int           lat;
        int           abort_at;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int tests  = 0;
    int failed = 0;

    exp_t exp_q[$];

    gcd_job_sequencer_if #(.W(W)) bus ();

    gcd_job_sequencer #(
        .W       (W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural GCD core: it is reset by rst or by core_abort, and done stays high until the next load.
    logic         m_done = 1'b0;
    logic         m_busy = 1'b0;
    logic [W-1:0] m_a    = '0;
    logic [W-1:0] m_b    = '0;
    logic [W-1:0] m_gcd  = '0;
    int           m_hold = 0;
    bit           hang   = 1'b0;
    int           stale_extra = 0;

    assign bus.core_done = m_done;
    assign bus.core_gcd  = m_gcd;

    always @(posedge clk) begin
        if (rst || bus.core_abort) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
            m_hold <= 0;
            m_gcd  <= '0;
        end else if (bus.core_load) begin
            m_a    <= bus.core_x;
            m_b    <= bus.core_y;
            m_busy <= 1'b1;
            m_hold <= stale_extra;
            if (stale_extra == 0) m_done <= 1'b0;
        end else if (m_busy) begin
            if (m_hold > 0) begin
                m_hold <= m_hold - 1;
                if (m_hold == 1) m_done <= 1'b0;
            end else if (!hang) begin
                if (m_a > m_b) m_a <= m_a - m_b;
                else if (m_b > m_a) m_b <= m_b - m_a;
                else begin
                    m_done <= 1'b1;
                    m_busy <= 1'b0;
                    m_gcd  <= m_a;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Per-job observations, restarted in the first cycle after each accept.
    int           since = 0;
    int           loads = 0;
    int           aborts = 0;
    int           overlap = 0;
    int           first_valid = 0;
    int           abort_at = 0;
    int           unstable = 0;
    bit           acc_last = 1'b0;
    bit           rst_last = 1'b1;
    logic [W-1:0] prev_x;
    logic [W-1:0] prev_y;

    task automatic checkOutput();
        exp_t e;
        check("sb_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_gcd", bus.out_gcd, e.gcd);
            check("out_err", bus.out_err, e.err);
            check("core_x", bus.core_x, e.x);
            check("core_y", bus.core_y, e.y);
            check("load_pulses", loads, e.loads);
            check("abort_pulses", aborts, e.aborts);
            check("load_abort_overlap", overlap, 0);
            check("operand_unstable", unstable, 0);
            if (e.lat >= 0) check("out_valid_latency", first_valid, e.lat);
            if (e.abort_at >= 0) check("abort_cycle", abort_at, e.abort_at);
        end
    endtask

    // Monitor: samples at negedge, away from the active edge.
    always @(negedge clk) begin
        if (acc_last) begin
            since       = 1;
            loads       = 0;
            aborts      = 0;
            overlap     = 0;
            first_valid = 0;
            abort_at    = 0;
            unstable    = 0;
        end else begin
            since++;
        end
        if (!rst) begin
            if (bus.core_load) loads++;
            if (bus.core_abort) begin
                aborts++;
                abort_at = since;
            end
            if (bus.core_load && bus.core_abort) overlap++;
            if (bus.out_valid && first_valid == 0) first_valid = since;
            if (!acc_last && !rst_last && (bus.core_x !== prev_x || bus.core_y !== prev_y)) unstable++;
            if (bus.out_valid && bus.out_ready) checkOutput();
        end
        acc_last = !rst && bus.in_valid && bus.in_ready;
        rst_last = rst;
        prev_x   = bus.core_x;
        prev_y   = bus.core_y;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue one pair; returns one step after the accepting edge.
    task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, input bit push,
                                 input logic [W-1:0] gcd, input logic err, input int nloads,
                                 input int naborts, input int lat, input int abort_cycle);
        exp_t e;
        int   n;
        if (push) begin
            e.x = x; e.y = y; e.gcd = gcd; e.err = err;
            e.loads = nloads; e.aborts = naborts; e.lat = lat; e.abort_at = abort_cycle;
            exp_q.push_back(e);
        end
        bus.in_x     = x;
        bus.in_y     = y;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            tick(1);
            n++;
        end
        check("accept_in_time", n < 200, 1);
        tick(1);
        bus.in_valid = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick(1);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;

        $display("[TB] reset state");
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_core_load", bus.core_load, 0);
        check("rst_core_abort", bus.core_abort, 0);
        check("rst_out_err", bus.out_err, 0);
        check("rst_out_gcd", bus.out_gcd, 0);
        check("rst_core_x", bus.core_x, 0);
        check("rst_core_y", bus.core_y, 0);

        $display("[TB] normal job and zero bypass");
        applyStimulus(8'd12, 8'd18, 1'b1, 8'd6, 1'b0, 1, 0, 6, -1);
        applyStimulus(8'd0, 8'd9, 1'b1, 8'd9, 1'b0, 0, 0, 1, -1);
        applyStimulus(8'd0, 8'd0, 1'b1, 8'd0, 1'b0, 0, 0, 1, -1);
        applyStimulus(8'd7, 8'd0, 1'b1, 8'd7, 1'b0, 0, 0, 1, -1);
        waitDrain("drain_basic");

        $display("[TB] stale done from previous job");
        stale_extra = 0;
        applyStimulus(8'd5, 8'd5, 1'b1, 8'd5, 1'b0, 1, 0, 4, -1);
        waitDrain("drain_stale_a");
        stale_extra = 2;
        applyStimulus(8'd8, 8'd12, 1'b1, 8'd4, 1'b0, 1, 0, 8, -1);
        waitDrain("drain_stale_b");
        stale_extra = 0;

        $display("[TB] timeout");
        hang = 1'b1;
        applyStimulus(8'd9, 8'd6, 1'b1, 8'd0, 1'b1, 1, 1, TIMEOUT + 2, TIMEOUT + 1);
        waitDrain("drain_timeout");
        hang = 1'b0;

        $display("[TB] backpressure");
        bus.out_ready = 1'b0;
        applyStimulus(8'd14, 8'd21, 1'b1, 8'd7, 1'b0, 1, 0, -1, -1);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            tick(1);
            n++;
        end
        check("bp_valid_seen", bus.out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_out_gcd", bus.out_gcd, 7);
            check("bp_in_ready", bus.in_ready, 0);
            tick(1);
        end
        bus.out_ready = 1'b1;
        applyStimulus(8'd0, 8'd3, 1'b1, 8'd3, 1'b0, 0, 0, 1, -1);
        waitDrain("drain_bp");

        $display("[TB] reset during WAIT_DONE");
        hang = 1'b1;
        applyStimulus(8'd3, 8'd6, 1'b0, 8'd0, 1'b0, 0, 0, -1, -1);
        tick(4);
        rst = 1'b1;
        tick(1);
        rst  = 1'b0;
        hang = 1'b0;
        check("rr_in_ready", bus.in_ready, 1);
        check("rr_out_valid", bus.out_valid, 0);
        check("rr_core_load", bus.core_load, 0);
        check("rr_core_abort", bus.core_abort, 0);
        applyStimulus(8'd21, 8'd14, 1'b1, 8'd7, 1'b0, 1, 0, 6, -1);
        waitDrain("drain_final");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/gcd_job_sequencer.md
Name: gcd_job_sequencer

Overview:
- Upstream front-end for the GCD controller/datapath pair.
- Accepts operand pairs over a valid/ready handshake and holds them stable on the core operand bus.
- Issues the single-cycle load that starts the controller, waits for its level done, captures the result and presents it over an output valid/ready handshake.
- Shields the core from zero operands, which never terminate in the subtract loop, and from hung jobs via a timeout with abort.

Parameters:
- W, 8, operand/result width in bits.
- TIMEOUT, 1024, max cycles from the load pulse to done before the job is aborted; counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept a pair.
- in_x  in  W  operand x.
- in_y  in  W  operand y.
- core_x  out  W  registered operand x to the datapath.
- core_y  out  W  registered operand y to the datapath.
- core_load  out  1  one-cycle start pulse to the controller load input.
- core_abort  out  1  one-cycle pulse, ORed by the top level into the controller/datapath reset.
- core_done  in  1  controller done; level, high while the controller is in its finished state.
- core_gcd  in  W  datapath result, valid while core_done=1.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_gcd  out  W  result.
- out_err  out  1  1 = job timed out, out_gcd=0.

Behaviour:
- Reset values: state=IDLE; in_ready=1 (decoded from IDLE); out_valid, core_load, core_abort, out_err = 0; core_x, core_y, out_gcd = 0; timeout counter = 0.
- rst asserted in any state returns the block to IDLE on the next edge. Any in-flight job is discarded, with no output and no abort pulse; the core is reset by the same rst.
- in_ready=1 only in IDLE. Transfers occur on in_valid&in_ready and on out_valid&out_ready.
- IDLE, on accept:
  - Latch in_x/in_y into core_x/core_y.
  - If in_x==0 or in_y==0: out_gcd=in_x|in_y (gcd(0,n)=n, gcd(0,0)=0), out_err=0, go to RESP. The core is never loaded.
  - Otherwise go to LAUNCH.
- LAUNCH: core_load=1 for exactly this cycle; clear the counter; go to WAIT_CLR.
- WAIT_CLR:
  - Wait for core_done==0, so a stale done held high from the previous job is never captured.
  - The counter increments every cycle; go to WAIT_DONE when core_done==0.
- WAIT_DONE:
  - The counter increments every cycle.
  - On core_done==1: out_gcd=core_gcd, out_err=0, go to RESP.
  - Otherwise, if the counter reaches TIMEOUT: core_abort=1 for one cycle, out_gcd=0, out_err=1, go to RESP.
  - If done and the timeout expiry occur in the same cycle, done wins.
- The timeout also applies in WAIT_CLR: expiry there aborts identically.
- RESP:
  - out_valid=1; out_gcd and out_err are held stable until accepted.
  - On out_ready: go to IDLE, drop out_valid.
  - out_ready may be high before out_valid. A result appears for one cycle minimum; there is no combinational path from out_ready to in_ready.
- core_x and core_y hold stable from accept until the next accept.
- Latency, measured from the accept edge:
  - Zero bypass: out_valid on cycle 1.
  - Normal job: core_load on cycle 1; out_valid 1 cycle after the first cycle in which core_done=1 is seen in WAIT_DONE.
- core_load and core_abort are never high simultaneously.

Optional Feature:
- Macro: GCD_CYCLE_COUNT_EN.
- Defined:
  - Adds output out_cycles [15:0]: the number of cycles from the LAUNCH cycle (exclusive) to the capture cycle (inclusive), saturating at 16'hFFFF.
  - Zero bypass reports 0; a timeout reports TIMEOUT.
  - Held with out_gcd; reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Accept (12,18); core model runs a subtract GCD -> exactly one core_load pulse, out_gcd=6, out_err=0, core_x=12 and core_y=18 stable throughout.
- Accept (0,9), then (0,0) -> out_valid on cycle 1 with out_gcd=9, then out_gcd=0; core_load never asserted.
- Core model holds core_done=1 from the previous job into the LAUNCH cycle, drops it for 1 cycle, then raises it with core_gcd=5 -> out_gcd=5; the stale done is not captured.
- TIMEOUT=16, core_done held 0 -> core_abort a single pulse at cycle 16 after LAUNCH, out_err=1, out_gcd=0, no core_load in the same cycle.
- Result 7 ready with out_ready=0 for 10 cycles -> out_valid, out_gcd=7 held, in_ready=0; release out_ready -> IDLE, next pair accepted.
- rst asserted in WAIT_DONE -> next cycle in_ready=1, out_valid=0, core_load=0, core_abort=0; a following (21,14) job yields 7.
